// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle of the fifo write arbiter: producer streams in, one fifo write port out.
// The master modport is the arbiter; the slave modport is the producers plus the fifo.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic [ID_W-1:0]          out_id;
  logic                     out_ready;
  logic                     grant_active;
  logic [ID_W-1:0]          grant_id;

  modport master (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, grant_active, grant_id
  );

  modport slave (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, grant_active, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NUM_REQ producers, with bursts
// of up to MAX_BURST beats per grant and a one-entry output register carrying data + id.
//
// state | meaning
// IDLE  | no owner; scan from rr_ptr for the next valid requester
// GRANT | grant_id owns the write port until its burst ends or it drops valid
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BW   = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    pick;
  logic [ID_W-1:0]    ptr_after_grant;
  logic [BW-1:0]      burst_cnt;
  logic               found;
  logic               start;
  logic               beat;
  logic               release_g;
  logic               slot_free;
  logic [NUM_REQ-1:0] req_ready;
  logic [WIDTH-1:0]   sel_data;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [ID_W-1:0]    out_id;
  int                 scan_idx;

  // First valid requester at or after rr_ptr; the wrap is explicit so non-power-of-2
  // NUM_REQ never aliases through ID_W overflow.
  always_comb begin
    found    = 1'b0;
    pick     = rr_ptr;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!found && bus.req_valid[ID_W'(scan_idx)]) begin
        found = 1'b1;
        pick  = ID_W'(scan_idx);
      end
    end
  end

  // Data lane of the current owner.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) sel_data = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  // The output slot can take a beat when empty or draining this cycle.
  assign slot_free       = !out_valid || bus.out_ready;
  assign ptr_after_grant = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, owner handshake and release decision.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    beat      = 1'b0;
    release_g = 1'b0;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (found) begin
          start     = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        req_ready[grant_id] = slot_free;
        beat      = bus.req_valid[grant_id] && slot_free;
        release_g = !bus.req_valid[grant_id] ||
                    (beat && burst_cnt == BW'(MAX_BURST - 1));
        if (release_g) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) req_ready = '0;
  end

  // Owner, burst length and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
    end else begin
      if (start) begin
        grant_id  <= pick;
        burst_cnt <= '0;
      end else if (beat) begin
        burst_cnt <= burst_cnt + BW'(1);
      end
      if (release_g) rr_ptr <= ptr_after_grant;
    end
  end

  // One-entry output register; a held beat stays put until the fifo takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (beat) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_id    <= grant_id;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_data;
  assign bus.out_id       = out_id;
  assign bus.grant_active = (state == GRANT);
  assign bus.grant_id     = grant_id;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a random soak into a 16-deep fifo,
// all checked against a rule-level model and an accept-order scoreboard.
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int MB    = 4;
  localparam int IW    = $clog2(N);
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  int prod_seq  [N];
  int prod_base [N];

  // model: who owns the port, beats taken, next scan start, output slot
  bit           m_grant;
  bit           m_ov;
  int           m_g;
  int           m_cnt;
  int           m_ptr;
  int           m_oid;
  logic [W-1:0] m_od;

  logic [IW+W-1:0] exp_q [$];
  logic [IW+W-1:0] sink  [$];

  logic          obs_ga;
  logic          obs_ov;
  logic [IW-1:0] obs_gid;
  logic [N-1:0]  obs_rdy;
  logic [N-1:0]  obs_hs;
  logic [W-1:0]  obs_od;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] data_of(input int i);
    return W'(prod_base[i] + prod_seq[i]);
  endfunction

  // One clock: drive inputs, check DUT against the model, feed the fifo, advance the model.
  task automatic step(input logic r, input logic [N-1:0] v, input logic ordy, input bit pop);
    logic [N-1:0]    exp_rdy;
    logic [IW+W-1:0] e;
    bit              beat;
    bit              found;
    @(negedge clk);
    rst           = r;
    bus.req_valid = v;
    bus.out_ready = ordy;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = data_of(i);
    #1;
    exp_rdy = '0;
    if (!r && m_grant && (!m_ov || ordy)) exp_rdy[m_g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("grant_active", 32'(bus.grant_active), 32'(m_grant));
    if (m_grant) chk("grant_id", 32'(bus.grant_id), 32'(m_g));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("out_data", 32'(bus.out_data), 32'(m_od));
    chk("out_id", 32'(bus.out_id), 32'(m_oid));
    obs_ga  = bus.grant_active;
    obs_ov  = bus.out_valid;
    obs_gid = bus.grant_id;
    obs_rdy = bus.req_ready;
    obs_hs  = bus.req_ready & v;
    obs_od  = bus.out_data;

    if (bus.out_valid && ordy && !r) sink.push_back({bus.out_id, bus.out_data});
    if (pop && sink.size() > 0) begin
      e = sink.pop_front();
      chk("sb_pending", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) chk("sb_order", 32'(e), 32'(exp_q.pop_front()));
    end

    if (r) begin
      if (m_ov && exp_q.size() > 0) void'(exp_q.pop_back());
      m_grant = 0; m_ov = 0; m_g = 0; m_cnt = 0; m_ptr = 0; m_oid = 0; m_od = '0;
    end else begin
      beat = m_grant && v[m_g] && (!m_ov || ordy);
      if (beat) begin
        m_od  = data_of(m_g);
        m_oid = m_g;
        m_ov  = 1;
        exp_q.push_back({IW'(m_g), data_of(m_g)});
        prod_seq[m_g]++;
      end else if (ordy) begin
        m_ov = 0;
      end
      if (m_grant) begin
        if ((beat && m_cnt == MB - 1) || !v[m_g]) begin
          m_grant = 0;
          m_ptr   = (m_g + 1) % N;
        end else if (beat) begin
          m_cnt++;
        end
      end else begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && v[(m_ptr + k) % N]) begin
            found   = 1;
            m_g     = (m_ptr + k) % N;
            m_cnt   = 0;
            m_grant = 1;
          end
        end
      end
    end
    @(posedge clk);
  endtask

  initial begin
    int           beats;
    int           idle;
    int           start_ptr;
    int           nrise;
    bit           prev_ga;
    bit           had_fall;
    logic [N-1:0] rv;
    logic         ordy;

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    m_grant = 0; m_ov = 0; m_g = 0; m_cnt = 0; m_ptr = 0; m_oid = 0; m_od = '0;
    for (int i = 0; i < N; i++) begin
      prod_seq[i]  = 0;
      prod_base[i] = i * 64;
    end

    // T1: reset held with every requester valid
    repeat (2) begin
      step(1'b1, '1, 1'b0, 1'b1);
      chk("t1_ga", 32'(obs_ga), 32'(0));
      chk("t1_ov", 32'(obs_ov), 32'(0));
      chk("t1_rdy", 32'(obs_rdy), 32'(0));
    end
    step(1'b0, '0, 1'b1, 1'b1);

    // T2: lone requester 2, data 0x10..0x13
    prod_base[2] = 8'h10 - prod_seq[2];
    beats = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 4'b0100, 1'b1, 1'b1);
      if (c == 1) begin
        chk("t2_ga", 32'(obs_ga), 32'(1));
        chk("t2_gid", 32'(obs_gid), 32'(2));
      end
      if (obs_hs[2]) beats++;
    end
    chk("t2_beats", 32'(beats), 32'(4));
    repeat (3) step(1'b0, '0, 1'b1, 1'b1);

    // T3: everyone valid, grants rotate in bursts of MAX_BURST with one idle gap
    start_ptr = m_ptr;
    prev_ga   = 0;
    had_fall  = 0;
    nrise     = 0;
    beats     = 0;
    idle      = 0;
    for (int c = 0; c < 40; c++) begin
      step(1'b0, '1, 1'b1, 1'b1);
      if (obs_ga && !prev_ga) begin
        chk("t3_order", 32'(obs_gid), 32'((start_ptr + nrise) % N));
        if (had_fall) chk("t3_gap", 32'(idle), 32'(1));
        nrise++;
        beats = 0;
      end
      if (!obs_ga && prev_ga) begin
        chk("t3_burst", 32'(beats), 32'(MB));
        had_fall = 1;
        idle     = 0;
      end
      if (!obs_ga) idle++;
      if (obs_ga && |obs_hs) beats++;
      prev_ga = obs_ga;
    end
    chk("t3_grants", 32'(nrise >= 7), 32'(1));
    repeat (3) step(1'b0, '0, 1'b1, 1'b1);

    // T4: five-cycle stall in the middle of a burst
    repeat (3) step(1'b0, '1, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, '1, 1'b0, 1'b0);
      chk("t4_ov", 32'(obs_ov), 32'(1));
      chk("t4_hold", 32'(obs_od), 32'(exp_q[exp_q.size()-1][W-1:0]));
      chk("t4_rdy", 32'(obs_rdy), 32'(0));
    end
    repeat (10) step(1'b0, '1, 1'b1, 1'b1);

    // Reset while a beat is held: the beat is dropped, the grant is aborted
    repeat (2) step(1'b0, '1, 1'b0, 1'b1);
    step(1'b1, '1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("rst_ov", 32'(obs_ov), 32'(0));
    chk("rst_ga", 32'(obs_ga), 32'(0));
    repeat (3) step(1'b0, '0, 1'b1, 1'b1);

    // T5: requester 1 drops valid after two beats, then 0 and 3 compete
    beats = 0;
    repeat (3) begin
      step(1'b0, 4'b0010, 1'b1, 1'b1);
      if (obs_hs[1]) beats++;
    end
    chk("t5_beats", 32'(beats), 32'(2));
    step(1'b0, 4'b0000, 1'b1, 1'b1);
    step(1'b0, 4'b1001, 1'b1, 1'b1);
    chk("t5_idle", 32'(obs_ga), 32'(0));
    step(1'b0, 4'b1001, 1'b1, 1'b1);
    chk("t5_ga", 32'(obs_ga), 32'(1));
    chk("t5_gid", 32'(obs_gid), 32'(3));
    repeat (3) step(1'b0, '0, 1'b1, 1'b1);

    // T6: random valids and fifo backpressure
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) rv[i] = ($urandom_range(0, 99) < 70);
      ordy = (sink.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      step(1'b0, rv, ordy, $urandom_range(0, 2) != 0);
    end

    repeat (10) step(1'b0, '0, 1'b1, 1'b1);
    repeat (DEPTH + 4) step(1'b0, '0, 1'b0, 1'b1);
    chk("drain_exp", 32'(exp_q.size()), 32'(0));
    chk("drain_sink", 32'(sink.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
